// File: rtl/lifo_stack_responder_if.sv
// Request/status bundle for lifo_stack_responder: the initiator drives the
// requests and data, and the stack drives the acknowledges, flags and occupancy.
interface lifo_stack_responder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int SPW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] din;
    logic                  push;
    logic                  pop;
    logic                  clear;
    logic [DATA_WIDTH-1:0] dout;
    logic [DATA_WIDTH-1:0] top;
    logic                  pushed;
    logic                  popped;
    logic                  ovf;
    logic                  unf;
    logic                  full;
    logic                  empty;
    logic                  busy;
    logic [SPW-1:0]        stack_pointer;

    modport master (
        output din, push, pop, clear,
        input  dout, top, pushed, popped, ovf, unf, full, empty, busy, stack_pointer
    );

    modport slave (
        input  din, push, pop, clear,
        output dout, top, pushed, popped, ovf, unf, full, empty, busy, stack_pointer
    );
endinterface

// File: rtl/lifo_stack_responder.sv
// LIFO stack with a four-state handshake: each held push/pop executes once,
// is acknowledged by a one-cycle pulse, and must be released before the next.
module lifo_stack_responder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input logic                  clk,
    input logic                  rst,
    lifo_stack_responder_if.slave bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    typedef enum logic [1:0] {IDLE, EXEC, ACK, RELEASE} state_t;
    typedef enum logic {OP_PUSH, OP_POP} op_t;
    typedef struct packed {
        op_t                   op;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    state_t                state_q, state_d;
    req_t                  req_q, req_d;
    logic [SPW-1:0]        sp_q, sp_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  pushed_q, pushed_d;
    logic                  popped_q, popped_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  mem_we;
    logic                  full_c, empty_c;
    logic [AW-1:0]         top_idx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign full_c  = (sp_q == SPW'(DEPTH));
    assign empty_c = (sp_q == '0);
    assign top_idx = AW'(sp_q - SPW'(1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!bus.clear && (bus.push || bus.pop)) state_d = EXEC;
            EXEC:    state_d = ACK;
            ACK:     state_d = RELEASE;
            RELEASE: if (!bus.push && !bus.pop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_d    = req_q;
        sp_d     = sp_q;
        dout_d   = dout_q;
        pushed_d = 1'b0;
        popped_d = 1'b0;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clear) begin
                    sp_d = '0;
                end else if (bus.push) begin
                    req_d.op   = OP_PUSH;
                    req_d.data = bus.din;
                end else if (bus.pop) begin
                    req_d.op = OP_POP;
                end
            end
            EXEC: begin
                // Refused operations leave pointer, memory and dout untouched.
                if (req_q.op == OP_PUSH) begin
                    if (!full_c) begin
                        mem_we   = 1'b1;
                        sp_d     = sp_q + SPW'(1);
                        pushed_d = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    if (!empty_c) begin
                        dout_d   = mem[top_idx];
                        sp_d     = sp_q - SPW'(1);
                        popped_d = 1'b1;
                    end else begin
                        unf_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q    <= '0;
            sp_q     <= '0;
            dout_q   <= '0;
            pushed_q <= 1'b0;
            popped_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            req_q    <= req_d;
            sp_q     <= sp_d;
            dout_q   <= dout_d;
            pushed_q <= pushed_d;
            popped_q <= popped_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage has no reset; slots at or above the pointer are never shown on top.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) mem[sp_q[AW-1:0]] <= req_q.data;
    end

    assign bus.dout          = dout_q;
    assign bus.top           = empty_c ? '0 : mem[top_idx];
    assign bus.pushed        = pushed_q;
    assign bus.popped        = popped_q;
    assign bus.ovf           = ovf_q;
    assign bus.unf           = unf_q;
    assign bus.full          = full_c;
    assign bus.empty         = empty_c;
    assign bus.busy          = (state_q != IDLE);
    assign bus.stack_pointer = sp_q;
endmodule

// File: tb/tb_lifo_stack_responder.sv
// Randomized scoreboard bench for lifo_stack_responder against a queue-based stack model.
module tb_lifo_stack_responder;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lifo_stack_responder_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();
    lifo_stack_responder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int kind;   // 0 pushed, 1 popped, 2 ovf, 3 unf
        int dout;
        int sp;
        int top;
        int full;
        int empty;
        int issue;
    } exp_t;

    exp_t sbq[$];
    int   model[$];
    int   last_dout;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    always @(posedge clk) cyc++;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    int   mon_n;
    int   mon_k;
    exp_t mon_e;
    always @(negedge clk) begin
        mon_n = int'(bus.pushed) + int'(bus.popped) + int'(bus.ovf) + int'(bus.unf);
        if (mon_n != 0) begin
            chk("pulse_onehot", mon_n, 1);
            if (sbq.size() == 0) begin
                chk("unexpected_pulse", mon_n, 0);
            end else begin
                mon_e = sbq.pop_front();
                mon_k = bus.pushed ? 0 : bus.popped ? 1 : bus.ovf ? 2 : 3;
                chk("ack_kind", mon_k, mon_e.kind);
                chk("ack_latency", cyc - mon_e.issue, 2);
                chk("dout", bus.dout, mon_e.dout);
                chk("stack_pointer", bus.stack_pointer, mon_e.sp);
                chk("top", bus.top, mon_e.top);
                chk("full", bus.full, mon_e.full);
                chk("empty", bus.empty, mon_e.empty);
            end
        end
    end

    task automatic op(input bit p, input bit q, input int d, input int hold);
        exp_t e;
        int   n;
        int   busy_low;
        @(negedge clk);
        if (p) begin
            if (model.size() < DEPTH) begin
                model.push_back(d);
                e.kind = 0;
            end else e.kind = 2;
        end else begin
            if (model.size() > 0) begin
                last_dout = model.pop_back();
                e.kind = 1;
            end else e.kind = 3;
        end
        e.dout  = last_dout;
        e.sp    = model.size();
        e.top   = (model.size() > 0) ? model[$] : 0;
        e.full  = (model.size() == DEPTH) ? 1 : 0;
        e.empty = (model.size() == 0) ? 1 : 0;
        e.issue = cyc;
        sbq.push_back(e);
        bus.push = p;
        bus.pop  = q;
        bus.din  = DW'(d);
        busy_low = 0;
        repeat (hold) begin
            @(negedge clk);
            if (!bus.busy) busy_low++;
            bus.din = DW'($urandom);
        end
        chk("busy_while_held", busy_low, 0);
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("release_to_idle", bus.busy, 0);
        chk("scoreboard_drained", sbq.size(), 0);
    endtask

    task automatic do_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        model.delete();
        chk("clear_sp", bus.stack_pointer, 0);
        chk("clear_empty", bus.empty, 1);
        chk("clear_top", bus.top, 0);
        chk("clear_busy", bus.busy, 0);
        chk("clear_dout", bus.dout, last_dout);
    endtask

    task automatic check_reset_state(string tag);
        chk({tag, "_sp"}, bus.stack_pointer, 0);
        chk({tag, "_dout"}, bus.dout, 0);
        chk({tag, "_empty"}, bus.empty, 1);
        chk({tag, "_full"}, bus.full, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_top"}, bus.top, 0);
        chk({tag, "_pulses"}, {bus.pushed, bus.popped, bus.ovf, bus.unf}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 500000", $time);
        $fatal(1);
    end

    initial begin
        int r;
        rst       = 1'b1;
        bus.din   = '0;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        bus.clear = 1'b0;
        last_dout = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        op(1, 0, 3, 3);
        op(1, 0, 5, 4);
        op(0, 1, 0, 3);
        op(0, 1, 0, 5);
        op(0, 1, 0, 3);

        for (int i = 1; i <= 9; i++) op(1, 0, i, 3);
        do_clear();

        op(1, 0, 7, 10);
        do_clear();

        op(1, 0, 4, 3);
        op(1, 1, 9, 3);

        // Reset lands on the EXEC cycle of a pop; nothing may be acknowledged.
        @(negedge clk);
        bus.pop = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.pop = 1'b0;
        model.delete();
        last_dout = 0;
        @(negedge clk);
        check_reset_state("reset_mid_exec");

        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 31));
            if (r == 0) do_clear();
            else if (r < 14) op(1, 0, int'($urandom_range(0, 255)), int'($urandom_range(3, 10)));
            else if (r < 28) op(0, 1, int'($urandom_range(0, 255)), int'($urandom_range(3, 10)));
            else op(1, 1, int'($urandom_range(0, 255)), int'($urandom_range(3, 10)));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
